writeback_arbiter: RTL and testbench
====================================

# writeback_arbiter

Merges register-file write requests from the single-cycle ALU path and the multi-cycle load path into the register file's single write port (RegWEn/AddrD/DataD). Load results that lose arbitration are buffered in a small FIFO. A per-register pending mask lets issue logic stall on registers whose load data has not yet reached the register file. The block sits between execute/memory and the register file, as the writer end of its write port.

## Interface
- DEPTH, 2, load-result FIFO depth; power of two, at least 2.
- XLEN, 32, data width.
- Clk  in  1  clock; all state updates on the rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- AluValid  in  1  ALU result valid; always accepted.
- AluRd  in  5  ALU destination register.
- AluData  in  XLEN  ALU result.
- LdValid  in  1  load result valid.
- LdReady  out  1  load result can be accepted.
- LdRd  in  5  load destination register.
- LdData  in  XLEN  load result.
- RegWEn  out  1  register-file write enable (registered).
- AddrD  out  5  register-file write address (registered).
- DataD  out  XLEN  register-file write data (registered).
- Pending  out  32  bit r set while a load to register r is queued or in the output stage.
- Count  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- **Load accept:** a load is accepted when LdValid && LdReady.
- **LdReady:** equals (Count < DEPTH). It is combinational from registered state only and never depends on LdValid or AluValid.
- **Selection:** one write source is chosen per cycle, in this priority order:
  1. ALU, if AluValid.
  2. FIFO head, if Count > 0.
  3. Load bypass, if the FIFO is empty and a load is accepted this cycle.
- **Losing load:** an accepted load that is not selected is pushed into the FIFO tail.
- **Same-cycle push and pop:** if the FIFO head is popped and a new load is pushed in the same cycle, Count is unchanged. The pointers wrap modulo DEPTH.
- **Ordering:**
  - Loads are written strictly in acceptance order. The bypass is legal only when the FIFO is empty.
  - Ordering between ALU and load writes is not enforced. Issue logic must use Pending to avoid write-after-write hazards on the same register.
- **Output stage:**
  - The selected request is registered: RegWEn <= 1, AddrD <= rd, DataD <= data.
  - If rd == 0, the request is consumed but RegWEn <= 0. AddrD and DataD still load the request's values.
  - If nothing is selected, RegWEn <= 0 and AddrD/DataD hold their previous values.
- **Pending:** bit r = OR over valid FIFO entries with rd == r, OR (RegWEn && the output stage came from a load && AddrD == r). Bit 0 is always 0.
- **Starvation:** with AluValid held high, the FIFO never drains, and LdReady stays low once the FIFO is full. This is permitted; upstream bounds ALU bursts.

## Timing
- **Reset (Rst_n low, asynchronous):**
  - RegWEn = 0, AddrD = 0, DataD = 0.
  - Count = 0, FIFO pointers = 0, Pending = 0, LdReady = 1.
- **Reset mid-operation:** all queued loads are discarded and no write is issued for them. Normal operation resumes on the first rising edge after Rst_n deasserts.
- **ALU path latency:** AluValid sampled at edge N → RegWEn/AddrD/DataD valid after edge N. The register file captures the value at edge N+1.
- **Load path latency:**
  - Empty FIFO and no ALU: same latency as the ALU path.
  - Otherwise: 1 + (number of ALU-won cycles) + (number of older FIFO entries) cycles.
- **Full and pop in the same cycle:** LdReady is still low in that cycle. It rises the cycle after the pop.
- **Pending timing:** a bit sets in the cycle after the load is accepted. It clears in the cycle after RegWEn for that write drops, i.e. once the register file holds the data.
- **Combinational paths:** LdReady, Count and Pending are driven purely from registers. There is no combinational path from any input to any output.

## Test plan
- **Reset:** assert Rst_n = 0 mid-burst with Count = 2 → outputs go to 0 immediately, Count = 0, Pending = 0. After release, no stale write appears.
- **ALU only:** AluValid with rd=5, data=32'hDEADBEEF at edge 1 → RegWEn=1, AddrD=5, DataD=32'hDEADBEEF after edge 1. The next cycle, rd=0 → RegWEn=0.
- **Load bypass:** empty FIFO, no ALU, load rd=7, data=32'h12345678 → written after one edge. Pending[7] is 1 for exactly one cycle (output-stage term).
- **Collision:** ALU rd=3 and load rd=4 in the same cycle, then idle → writes appear as r3, then r4 on consecutive cycles. Count goes 1 → 0. Pending[4] = 1 until the r4 write completes.
- **Full FIFO:** ALU held high for 4 cycles while loads rd=8, 9, 10 are offered →
  - loads 8 and 9 are accepted;
  - LdReady = 0 with Count = 2;
  - load 10 waits.
  After the ALU drops, the writes order is r8, r9, r10, and LdReady rises the cycle after the first pop.
- **Same-register ordering:** queue loads rd=6 with data 1, then data 2 → final write to r6 is 2. Pending[6] stays set across both entries and clears after the second write.

Source files
------------

// File: rtl/writeback_arbiter.sv
// Write-back arbiter: merges ALU and load results onto the register file's
// single write port, queueing load results that lose arbitration.
module writeback_arbiter #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic                   AluValid,
    input  logic [4:0]             AluRd,
    input  logic [XLEN-1:0]        AluData,
    input  logic                   LdValid,
    output logic                   LdReady,
    input  logic [4:0]             LdRd,
    input  logic [XLEN-1:0]        LdData,
    output logic                   RegWEn,
    output logic [4:0]             AddrD,
    output logic [XLEN-1:0]        DataD,
    output logic [31:0]            Pending,
    output logic [$clog2(DEPTH):0] Count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        SrcNone,
        SrcAlu,
        SrcFifo,
        SrcBypass
    } src_e;

    logic [4:0]      fifoRd   [DEPTH];
    logic [XLEN-1:0] fifoData [DEPTH];
    logic [PW-1:0]   headPtr;
    logic [PW-1:0]   tailPtr;
    logic            outFromLoad;
    logic [DEPTH-1:0] entryValid;

    src_e            src;
    logic [4:0]      selRd;
    logic [XLEN-1:0] selData;
    logic            ldAccept;
    logic            push;
    logic            pop;

    assign LdReady  = (Count < CW'(DEPTH));
    assign ldAccept = LdValid && LdReady;

    // Fixed priority: ALU, then oldest queued load, then a bypassing load.
    // The bypass only fires on an empty FIFO so loads stay in order.
    always_comb begin
        src     = SrcNone;
        selRd   = AluRd;
        selData = AluData;
        if (AluValid) begin
            src = SrcAlu;
        end else if (Count != '0) begin
            src     = SrcFifo;
            selRd   = fifoRd[headPtr];
            selData = fifoData[headPtr];
        end else if (ldAccept) begin
            src     = SrcBypass;
            selRd   = LdRd;
            selData = LdData;
        end
    end

    assign push = ldAccept && (src != SrcBypass);
    assign pop  = (src == SrcFifo);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            headPtr     <= '0;
            tailPtr     <= '0;
            Count       <= '0;
            RegWEn      <= 1'b0;
            AddrD       <= '0;
            DataD       <= '0;
            outFromLoad <= 1'b0;
        end else begin
            if (push) tailPtr <= tailPtr + PW'(1);
            if (pop)  headPtr <= headPtr + PW'(1);
            if (push && !pop)      Count <= Count + CW'(1);
            else if (pop && !push) Count <= Count - CW'(1);

            if (src != SrcNone) begin
                RegWEn      <= (selRd != 5'd0);
                AddrD       <= selRd;
                DataD       <= selData;
                outFromLoad <= (src != SrcAlu);
            end else begin
                RegWEn      <= 1'b0;
                outFromLoad <= 1'b0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            fifoRd[tailPtr]   <= LdRd;
            fifoData[tailPtr] <= LdData;
        end
    end

    // An entry is live when its distance from the head is below the occupancy.
    for (genvar g = 0; g < DEPTH; g++) begin : gEntry
        logic [PW-1:0] offset;
        assign offset        = PW'(g) - headPtr;
        assign entryValid[g] = ({1'b0, offset} < Count);
    end

    always_comb begin
        Pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entryValid[i]) Pending[fifoRd[i]] = 1'b1;
        end
        if (RegWEn && outFromLoad) Pending[AddrD] = 1'b1;
        Pending[0] = 1'b0;
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: a vector table for single-cycle
// behaviour plus hand-written sequences for queueing, full FIFO and reset.
module tb_writeback_arbiter;
    localparam int DEPTH = 2;
    localparam int XLEN  = 32;

    logic            Clk;
    logic            Rst_n;
    logic            AluValid;
    logic [4:0]      AluRd;
    logic [XLEN-1:0] AluData;
    logic            LdValid;
    logic            LdReady;
    logic [4:0]      LdRd;
    logic [XLEN-1:0] LdData;
    logic            RegWEn;
    logic [4:0]      AddrD;
    logic [XLEN-1:0] DataD;
    logic [31:0]     Pending;
    logic [1:0]      Count;

    int errorCount = 0;
    int checkCount = 0;

    typedef struct packed {
        logic        aluValid;
        logic [4:0]  aluRd;
        logic [31:0] aluData;
        logic        ldValid;
        logic [4:0]  ldRd;
        logic [31:0] ldData;
        logic        expWEn;
        logic [4:0]  expAddr;
        logic [31:0] expData;
        logic [1:0]  expCount;
        logic        expReady;
        logic [31:0] expPending;
    } vec_t;

    vec_t vecs [9];

    writeback_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .AluValid (AluValid),
        .AluRd    (AluRd),
        .AluData  (AluData),
        .LdValid  (LdValid),
        .LdReady  (LdReady),
        .LdRd     (LdRd),
        .LdData   (LdData),
        .RegWEn   (RegWEn),
        .AddrD    (AddrD),
        .DataD    (DataD),
        .Pending  (Pending),
        .Count    (Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic applyStimulus(input logic aV, input logic [4:0] aRd, input logic [31:0] aD,
                                 input logic lV, input logic [4:0] lRd, input logic [31:0] lD);
        AluValid = aV;
        AluRd    = aRd;
        AluData  = aD;
        LdValid  = lV;
        LdRd     = lRd;
        LdData   = lD;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic checkOne(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic eWEn, input logic [4:0] eAddr,
                               input logic [31:0] eData, input logic [1:0] eCount,
                               input logic eReady, input logic [31:0] ePending);
        checkOne({name, ".RegWEn"},  {31'd0, RegWEn},  {31'd0, eWEn});
        checkOne({name, ".AddrD"},   {27'd0, AddrD},   {27'd0, eAddr});
        checkOne({name, ".DataD"},   DataD,            eData);
        checkOne({name, ".Count"},   {30'd0, Count},   {30'd0, eCount});
        checkOne({name, ".LdReady"}, {31'd0, LdReady}, {31'd0, eReady});
        checkOne({name, ".Pending"}, Pending,          ePending);
    endtask

    initial begin
        // {aluValid, aluRd, aluData, ldValid, ldRd, ldData,
        //  expWEn, expAddr, expData, expCount, expReady, expPending}
        vecs[0] = {1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 32'hDEADBEEF, 2'd0, 1'b1, 32'h0};
        vecs[1] = {1'b1, 5'd0, 32'h00000011, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h00000011, 2'd0, 1'b1, 32'h0};
        vecs[2] = {1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h00000011, 2'd0, 1'b1, 32'h0};
        vecs[3] = {1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h12345678, 1'b1, 5'd7, 32'h12345678, 2'd0, 1'b1, 32'h80};
        vecs[4] = {1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd7, 32'h12345678, 2'd0, 1'b1, 32'h0};
        vecs[5] = {1'b1, 5'd3, 32'h000000A3, 1'b1, 5'd4, 32'h000000B4, 1'b1, 5'd3, 32'h000000A3, 2'd1, 1'b1, 32'h10};
        vecs[6] = {1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 32'h000000B4, 2'd0, 1'b1, 32'h10};
        vecs[7] = {1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd4, 32'h000000B4, 2'd0, 1'b1, 32'h0};
        vecs[8] = {1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h00000055, 1'b0, 5'd0, 32'h00000055, 2'd0, 1'b1, 32'h0};

        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        Rst_n = 1'b0;
        #2;
        checkOutput("reset", 1'b0, 5'd0, 32'h0, 2'd0, 1'b1, 32'h0);
        step();
        Rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].aluValid, vecs[i].aluRd, vecs[i].aluData,
                          vecs[i].ldValid, vecs[i].ldRd, vecs[i].ldData);
            step();
            checkOutput($sformatf("vec%0d", i), vecs[i].expWEn, vecs[i].expAddr, vecs[i].expData,
                        vecs[i].expCount, vecs[i].expReady, vecs[i].expPending);
        end

        // Full FIFO: ALU owns the port for four cycles while loads 8, 9, 10 arrive.
        applyStimulus(1'b1, 5'd20, 32'h20, 1'b1, 5'd8, 32'h808);
        step();
        checkOutput("full.c1", 1'b1, 5'd20, 32'h20, 2'd1, 1'b1, 32'h100);
        applyStimulus(1'b1, 5'd21, 32'h21, 1'b1, 5'd9, 32'h909);
        step();
        checkOutput("full.c2", 1'b1, 5'd21, 32'h21, 2'd2, 1'b0, 32'h300);
        applyStimulus(1'b1, 5'd22, 32'h22, 1'b1, 5'd10, 32'hA0A);
        step();
        checkOutput("full.c3", 1'b1, 5'd22, 32'h22, 2'd2, 1'b0, 32'h300);
        applyStimulus(1'b1, 5'd23, 32'h23, 1'b1, 5'd10, 32'hA0A);
        step();
        checkOutput("full.c4", 1'b1, 5'd23, 32'h23, 2'd2, 1'b0, 32'h300);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'hA0A);
        step();
        checkOutput("full.c5", 1'b1, 5'd8, 32'h808, 2'd1, 1'b1, 32'h300);
        step();
        checkOutput("full.c6", 1'b1, 5'd9, 32'h909, 2'd1, 1'b1, 32'h600);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        step();
        checkOutput("full.c7", 1'b1, 5'd10, 32'hA0A, 2'd0, 1'b1, 32'h400);
        step();
        checkOutput("full.c8", 1'b0, 5'd10, 32'hA0A, 2'd0, 1'b1, 32'h0);

        // Two queued loads to r6: the later value must land last.
        applyStimulus(1'b1, 5'd1, 32'hA1, 1'b1, 5'd6, 32'h1);
        step();
        checkOutput("same.c1", 1'b1, 5'd1, 32'hA1, 2'd1, 1'b1, 32'h40);
        applyStimulus(1'b1, 5'd2, 32'hA2, 1'b1, 5'd6, 32'h2);
        step();
        checkOutput("same.c2", 1'b1, 5'd2, 32'hA2, 2'd2, 1'b0, 32'h40);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        step();
        checkOutput("same.c3", 1'b1, 5'd6, 32'h1, 2'd1, 1'b1, 32'h40);
        step();
        checkOutput("same.c4", 1'b1, 5'd6, 32'h2, 2'd0, 1'b1, 32'h40);
        step();
        checkOutput("same.c5", 1'b0, 5'd6, 32'h2, 2'd0, 1'b1, 32'h0);

        // Reset mid-burst with two loads queued; nothing stale may be written after release.
        applyStimulus(1'b1, 5'd11, 32'hB1, 1'b1, 5'd12, 32'hC2);
        step();
        applyStimulus(1'b1, 5'd13, 32'hB3, 1'b1, 5'd14, 32'hC4);
        step();
        checkOutput("rst.pre", 1'b1, 5'd13, 32'hB3, 2'd2, 1'b0, 32'h5000);
        #2;
        Rst_n = 1'b0;
        #1;
        checkOutput("rst.async", 1'b0, 5'd0, 32'h0, 2'd0, 1'b1, 32'h0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        step();
        Rst_n = 1'b1;
        step();
        checkOutput("rst.post1", 1'b0, 5'd0, 32'h0, 2'd0, 1'b1, 32'h0);
        step();
        checkOutput("rst.post2", 1'b0, 5'd0, 32'h0, 2'd0, 1'b1, 32'h0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
